// File: rtl/act_pingpong_buffer_pkg.sv
// act_pingpong_buffer_pkg: default array geometry and the byte/width helpers shared by the buffer and its gearbox
package act_pingpong_buffer_pkg;
  localparam int ARRAY_ROW = 12;
  function automatic int row_bytes(input int row_w);
    return row_w / 8;
  endfunction
  function automatic int acc_bytes(input int s_w, input int row_w);
    return (s_w + row_w) / 8;
  endfunction
  function automatic int fill_w(input int s_w, input int row_w);
    return $clog2(2 * acc_bytes(s_w, row_w) + 1);
  endfunction
endpackage

// File: rtl/act_pingpong_buffer_if.sv
// act_pingpong_buffer_if: AXI-Stream beat channel; master drives tdata/tvalid/tlast, slave drives tready
interface act_pingpong_buffer_if #(parameter int S_W = 64);
  logic [S_W-1:0] tdata;
  logic tvalid, tready, tlast;
  modport master(output tdata, tvalid, tlast, input tready);
  modport slave(input tdata, tvalid, tlast, output tready);
endinterface

// File: rtl/act_pingpong_buffer_axis_row_gearbox.sv
// axis_row_gearbox: packs S_W beats into ROW_W rows with zero-padded frame tail; ports: tdata/tvalid/tlast/tready beat in, bank_full/seal from top, row/row_vld/row_last out
module axis_row_gearbox
  import act_pingpong_buffer_pkg::*;
#(
  parameter int S_W   = 64,
  parameter int ROW_W = ARRAY_ROW * 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [S_W-1:0]   tdata,
  input  logic             tvalid,
  input  logic             tlast,
  output logic             tready,
  input  logic             bank_full,
  input  logic             seal,
  output logic [ROW_W-1:0] row,
  output logic             row_vld,
  output logic             row_last
);
  localparam int SB = S_W / 8;
  localparam int RB = row_bytes(ROW_W);
  localparam int AB = acc_bytes(S_W, ROW_W);
  localparam int AW = AB * 8;
  localparam int FW = fill_w(S_W, ROW_W);
  logic [AW-1:0] acc_q, acc_d, base;
  logic [FW-1:0] fill_q, fill_d, nf;
  logic flushing_q, flushing_d, accept;
  // bytes above fill are always zero, so a short tail row comes out already padded
  always_comb begin
    row_vld    = fill_q >= FW'(RB) || (flushing_q && fill_q != '0);
    row_last   = row_vld && flushing_q && fill_q <= FW'(RB);
    nf         = !row_vld ? fill_q : fill_q >= FW'(RB) ? fill_q - FW'(RB) : '0;
    tready     = !bank_full && !flushing_q && (nf + FW'(SB) <= FW'(AB));
    accept     = tvalid && tready;
    base       = row_vld ? acc_q >> (RB * 8) : acc_q;
    acc_d      = accept ? base | (AW'(tdata) << {nf, 3'b000}) : base;
    fill_d     = accept ? nf + FW'(SB) : nf;
    flushing_d = !seal && (flushing_q || (accept && tlast));
  end
  assign row = acc_q[ROW_W-1:0];
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q      <= '0;
      fill_q     <= '0;
      flushing_q <= 1'b0;
    end else begin
      acc_q      <= acc_d;
      fill_q     <= fill_d;
      flushing_q <= flushing_d;
    end
  end
endmodule

// File: rtl/act_pingpong_buffer.sv
// act_pingpong_buffer: two-bank activation buffer; ports: s_axis stream in, i_rd_en/o_array_vec/o_vec_valid row reads, o_rd_bank_ready/o_rd_rows/i_rd_release bank handshake, o_overflow/i_clr_err error
module act_pingpong_buffer
  import act_pingpong_buffer_pkg::*;
#(
  parameter int S_W        = 64,
  parameter int ROW_W      = ARRAY_ROW * 8,
  parameter int DEPTH_LOG2 = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  act_pingpong_buffer_if.slave s_axis,
  input  logic                 i_rd_en,
  output logic [ROW_W-1:0]     o_array_vec,
  output logic                 o_vec_valid,
  output logic                 o_rd_bank_ready,
  output logic [DEPTH_LOG2:0]  o_rd_rows,
  input  logic                 i_rd_release,
  output logic                 o_overflow,
  input  logic                 i_clr_err
);
  localparam int D = DEPTH_LOG2;
  logic [ROW_W-1:0] ram [2**(D+1)];
  logic [ROW_W-1:0] row, wdat_q, wdat_d, ram_rd_q, vec_q, vec_d;
  logic row_vld, row_last, wv_q, wv_d, wl_q, wl_d;
  logic [D:0] wr_row_q, wr_row_d, wr_row_nx, rd_ptr_q, rd_ptr_d;
  logic [1:0][D:0] cnt_q, cnt_d;
  logic [1:0] full_q, full_d;
  logic wr_bank_q, wr_bank_d, rd_bank_q, rd_bank_d, rd_pend_q, rd_pend_d;
  logic vld_q, vld_d, ovf_q, ovf_d, we, rd_hit, rel;
  axis_row_gearbox #(.S_W(S_W), .ROW_W(ROW_W)) u_gearbox (
    .clk      (clk),
    .rst_n    (rst_n),
    .tdata    (s_axis.tdata),
    .tvalid   (s_axis.tvalid),
    .tlast    (s_axis.tlast),
    .tready   (s_axis.tready),
    .bank_full(full_q[wr_bank_q]),
    .seal     (wl_q),
    .row      (row),
    .row_vld  (row_vld),
    .row_last (row_last)
  );
  // emitted rows are staged one cycle; the seal lands on the same edge as the final row write
  always_comb begin
    we        = wv_q && !wr_row_q[D];
    wr_row_nx = wr_row_q + (D+1)'(we);
    rel       = i_rd_release && full_q[rd_bank_q];
    rd_hit    = i_rd_en && full_q[rd_bank_q] && rd_ptr_q < cnt_q[rd_bank_q];
    wv_d      = row_vld;
    wl_d      = row_last;
    wdat_d    = row_vld ? row : wdat_q;
    wr_row_d  = wl_q ? '0 : wr_row_nx;
    wr_bank_d = wr_bank_q ^ wl_q;
    rd_bank_d = rd_bank_q ^ rel;
    rd_ptr_d  = rel ? '0 : rd_ptr_q + (D+1)'(rd_hit);
    full_d    = full_q;
    cnt_d     = cnt_q;
    if (rel) full_d[rd_bank_q] = 1'b0;
    if (wl_q) begin
      full_d[wr_bank_q] = 1'b1;
      cnt_d[wr_bank_q]  = wr_row_nx;
    end
    ovf_d     = (ovf_q && !i_clr_err) || (wv_q && wr_row_q[D]);
    rd_pend_d = rd_hit;
    vld_d     = rd_pend_q;
    vec_d     = rd_pend_q ? ram_rd_q : vec_q;
  end
  always_ff @(posedge clk) begin
    if (we) ram[{wr_bank_q, wr_row_q[D-1:0]}] <= wdat_q;
    if (rd_hit) ram_rd_q <= ram[{rd_bank_q, rd_ptr_q[D-1:0]}];
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wv_q      <= 1'b0;
      wl_q      <= 1'b0;
      wdat_q    <= '0;
      wr_row_q  <= '0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b0;
      rd_ptr_q  <= '0;
      full_q    <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      rd_pend_q <= 1'b0;
      vld_q     <= 1'b0;
      vec_q     <= '0;
    end else begin
      wv_q      <= wv_d;
      wl_q      <= wl_d;
      wdat_q    <= wdat_d;
      wr_row_q  <= wr_row_d;
      wr_bank_q <= wr_bank_d;
      rd_bank_q <= rd_bank_d;
      rd_ptr_q  <= rd_ptr_d;
      full_q    <= full_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      rd_pend_q <= rd_pend_d;
      vld_q     <= vld_d;
      vec_q     <= vec_d;
    end
  end
  assign o_array_vec     = vec_q;
  assign o_vec_valid     = vld_q;
  assign o_rd_bank_ready = full_q[rd_bank_q];
  assign o_rd_rows       = cnt_q[rd_bank_q];
  assign o_overflow      = ovf_q;
endmodule

// File: tb/tb_act_pingpong_buffer.sv
// tb_act_pingpong_buffer: directed scenario bench for act_pingpong_buffer (4-row banks)
module tb_act_pingpong_buffer;
  localparam int S_W = 64, ROW_W = 96, D = 2, RB = ROW_W / 8;
  logic clk = 1'b0, rst_n = 1'b0, i_rd_en = 1'b0, i_rd_release = 1'b0, i_clr_err = 1'b0;
  logic [ROW_W-1:0] o_array_vec;
  logic o_vec_valid, o_rd_bank_ready, o_overflow;
  logic [D:0] o_rd_rows;
  int checks = 0, errors = 0;
  act_pingpong_buffer_if #(.S_W(S_W)) s_axis();
  act_pingpong_buffer #(.S_W(S_W), .ROW_W(ROW_W), .DEPTH_LOG2(D)) dut (
    .clk(clk), .rst_n(rst_n), .s_axis(s_axis), .i_rd_en(i_rd_en),
    .o_array_vec(o_array_vec), .o_vec_valid(o_vec_valid),
    .o_rd_bank_ready(o_rd_bank_ready), .o_rd_rows(o_rd_rows),
    .i_rd_release(i_rd_release), .o_overflow(o_overflow), .i_clr_err(i_clr_err)
  );
  always #5 clk = ~clk;
  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  function automatic logic [S_W-1:0] mk_beat(input int base);
    logic [S_W-1:0] v;
    for (int j = 0; j < S_W / 8; j++) v[j*8 +: 8] = 8'(base + j);
    return v;
  endfunction
  function automatic logic [ROW_W-1:0] exp_row(input int base, input int nbytes, input int r);
    logic [ROW_W-1:0] v;
    v = '0;
    for (int j = 0; j < RB; j++) if (r * RB + j < nbytes) v[j*8 +: 8] = 8'(base + r * RB + j);
    return v;
  endfunction
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic do_reset();
    rst_n = 1'b0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    s_axis.tdata = '0;
    i_rd_en = 1'b0;
    i_rd_release = 1'b0;
    i_clr_err = 1'b0;
    repeat (2) step();
    rst_n = 1'b1;
    step();
  endtask
  task automatic beat(input logic [S_W-1:0] d, input logic last, output int tries);
    bit ok;
    s_axis.tdata = d;
    s_axis.tvalid = 1'b1;
    s_axis.tlast = last;
    ok = 0;
    tries = 0;
    for (int i = 0; i < 50 && !ok; i++) begin
      @(negedge clk);
      ok = s_axis.tready;
      tries++;
      @(posedge clk);
      #1;
    end
    if (!ok) tries = 1000;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
  endtask
  task automatic send_frame(input int base, input int nbeats, output int stalls);
    int t;
    stalls = 0;
    for (int b = 0; b < nbeats; b++) begin
      beat(mk_beat(base + 8 * b), b == nbeats - 1, t);
      stalls += t - 1;
    end
  endtask
  task automatic wait_ready(output bit ok);
    for (int i = 0; i < 30 && !o_rd_bank_ready; i++) step();
    ok = o_rd_bank_ready;
  endtask
  task automatic read_row(output logic v0, output logic v1, output logic [ROW_W-1:0] d);
    i_rd_en = 1'b1;
    step();
    i_rd_en = 1'b0;
    v0 = o_vec_valid;
    step();
    v1 = o_vec_valid;
    d = o_array_vec;
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL reset_tready: got %b expected 1", s_axis.tready); end
    checks++; if (o_vec_valid !== 1'b0) begin errors++; $display("FAIL reset_vld: got %b expected 0", o_vec_valid); end
    checks++; if (o_array_vec !== '0) begin errors++; $display("FAIL reset_vec: got %h expected 0", o_array_vec); end
    checks++; if (o_rd_bank_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", o_rd_bank_ready); end
    checks++; if (o_rd_rows !== '0) begin errors++; $display("FAIL reset_rows: got %0d expected 0", o_rd_rows); end
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL reset_ovf: got %b expected 0", o_overflow); end
  endtask

  task automatic test_full_rows();
    int st;
    logic v0, v1;
    logic [ROW_W-1:0] d;
    do_reset();
    send_frame(0, 6, st);
    checks++; if (st !== 0) begin errors++; $display("FAIL t1_stalls: got %0d expected 0", st); end
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL t1_flush_tready: got %b expected 0", s_axis.tready); end
    step();
    checks++; if (o_rd_bank_ready !== 1'b0) begin errors++; $display("FAIL t1_ready_early: got %b expected 0", o_rd_bank_ready); end
    step();
    checks++; if (o_rd_bank_ready !== 1'b1) begin errors++; $display("FAIL t1_ready_seal: got %b expected 1", o_rd_bank_ready); end
    checks++; if (o_rd_rows !== 3'd4) begin errors++; $display("FAIL t1_rows: got %0d expected 4", o_rd_rows); end
    for (int r = 0; r < 4; r++) begin
      read_row(v0, v1, d);
      checks++;
      if ({v0, v1, d} !== {1'b0, 1'b1, exp_row(0, 48, r)}) begin
        errors++; $display("FAIL t1_row%0d: got v=%b%b %h expected v=01 %h", r, v0, v1, d, exp_row(0, 48, r));
      end
    end
    step();
    checks++; if ({o_vec_valid, o_array_vec} !== {1'b0, exp_row(0, 48, 3)}) begin errors++; $display("FAIL t1_hold: got %b %h expected 0 %h", o_vec_valid, o_array_vec, exp_row(0, 48, 3)); end
  endtask

  task automatic test_pad_row();
    int st;
    bit ok;
    logic v0, v1;
    logic [ROW_W-1:0] d;
    do_reset();
    send_frame(0, 4, st);
    wait_ready(ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL t2_ready: got %b expected 1", ok); end
    checks++; if (o_rd_rows !== 3'd3) begin errors++; $display("FAIL t2_rows: got %0d expected 3", o_rd_rows); end
    for (int r = 0; r < 3; r++) begin
      read_row(v0, v1, d);
      checks++;
      if ({v1, d} !== {1'b1, exp_row(0, 32, r)}) begin
        errors++; $display("FAIL t2_row%0d: got v=%b %h expected v=1 %h", r, v1, d, exp_row(0, 32, r));
      end
    end
    checks++; if (d !== 96'h00000000_1f1e1d1c1b1a1918) begin errors++; $display("FAIL t2_pad: got %h expected 000000001f1e1d1c1b1a1918", d); end
  endtask

  task automatic test_back_to_back();
    int st;
    bit ok;
    logic v0, v1;
    logic [ROW_W-1:0] d;
    do_reset();
    send_frame(0, 3, st);
    wait_ready(ok);
    send_frame(8'h40, 3, st);
    step();
    step();
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL t3_both_full: got %b expected 0", s_axis.tready); end
    s_axis.tdata = mk_beat(8'hA0);
    s_axis.tvalid = 1'b1;
    repeat (4) step();
    checks++; if (s_axis.tready !== 1'b0) begin errors++; $display("FAIL t3_stall: got %b expected 0", s_axis.tready); end
    s_axis.tvalid = 1'b0;
    i_rd_release = 1'b1;
    step();
    i_rd_release = 1'b0;
    checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL t3_tready_back: got %b expected 1", s_axis.tready); end
    checks++; if ({o_rd_bank_ready, o_rd_rows} !== {1'b1, 3'd2}) begin errors++; $display("FAIL t3_bank1: got ready=%b rows=%0d expected ready=1 rows=2", o_rd_bank_ready, o_rd_rows); end
    read_row(v0, v1, d);
    checks++; if ({v1, d} !== {1'b1, exp_row(8'h40, 24, 0)}) begin errors++; $display("FAIL t3_row0: got v=%b %h expected v=1 %h", v1, d, exp_row(8'h40, 24, 0)); end
  endtask

  task automatic test_overflow();
    int st;
    bit ok;
    logic v0, v1;
    logic [ROW_W-1:0] d;
    do_reset();
    send_frame(0, 9, st);
    wait_ready(ok);
    checks++; if (o_rd_rows !== 3'd4) begin errors++; $display("FAIL t4_rows: got %0d expected 4", o_rd_rows); end
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL t4_ovf: got %b expected 1", o_overflow); end
    repeat (3) step();
    checks++; if (o_overflow !== 1'b1) begin errors++; $display("FAIL t4_sticky: got %b expected 1", o_overflow); end
    i_clr_err = 1'b1;
    step();
    i_clr_err = 1'b0;
    checks++; if (o_overflow !== 1'b0) begin errors++; $display("FAIL t4_clr: got %b expected 0", o_overflow); end
    for (int r = 0; r < 4; r++) read_row(v0, v1, d);
    checks++; if ({v1, d} !== {1'b1, exp_row(0, 72, 3)}) begin errors++; $display("FAIL t4_row3: got v=%b %h expected v=1 %h", v1, d, exp_row(0, 72, 3)); end
    read_row(v0, v1, d);
    checks++; if ({v0, v1} !== 2'b00) begin errors++; $display("FAIL t4_beyond: got vld=%b%b expected 00", v0, v1); end
    checks++; if (d !== exp_row(0, 72, 3)) begin errors++; $display("FAIL t4_hold: got %h expected %h", d, exp_row(0, 72, 3)); end
  endtask

  task automatic test_seal_release();
    int st;
    bit ok;
    logic v0, v1;
    logic [ROW_W-1:0] d;
    do_reset();
    send_frame(0, 4, st);
    wait_ready(ok);
    send_frame(8'h60, 3, st);
    step();
    i_rd_release = 1'b1;
    checks++; if ({o_rd_bank_ready, o_rd_rows} !== {1'b1, 3'd3}) begin errors++; $display("FAIL t5_pre: got ready=%b rows=%0d expected ready=1 rows=3", o_rd_bank_ready, o_rd_rows); end
    step();
    i_rd_release = 1'b0;
    checks++; if ({o_rd_bank_ready, o_rd_rows} !== {1'b1, 3'd2}) begin errors++; $display("FAIL t5_post: got ready=%b rows=%0d expected ready=1 rows=2", o_rd_bank_ready, o_rd_rows); end
    checks++; if (s_axis.tready !== 1'b1) begin errors++; $display("FAIL t5_tready: got %b expected 1", s_axis.tready); end
    read_row(v0, v1, d);
    checks++; if ({v1, d} !== {1'b1, exp_row(8'h60, 24, 0)}) begin errors++; $display("FAIL t5_row0: got v=%b %h expected v=1 %h", v1, d, exp_row(8'h60, 24, 0)); end
  endtask

  task automatic test_reset_mid_frame();
    int st;
    bit ok;
    logic v0, v1;
    logic [ROW_W-1:0] d;
    do_reset();
    send_frame(0, 3, st);
    wait_ready(ok);
    read_row(v0, v1, d);
    beat(mk_beat(8'h20), 1'b0, st);
    beat(mk_beat(8'h28), 1'b0, st);
    #2;
    rst_n = 1'b0;
    #1;
    checks++; if ({s_axis.tready, o_vec_valid, o_rd_bank_ready, o_overflow} !== 4'b1000) begin errors++; $display("FAIL t6_flags: got %b expected 1000", {s_axis.tready, o_vec_valid, o_rd_bank_ready, o_overflow}); end
    checks++; if (o_array_vec !== '0) begin errors++; $display("FAIL t6_vec: got %h expected 0", o_array_vec); end
    checks++; if (o_rd_rows !== '0) begin errors++; $display("FAIL t6_rows0: got %0d expected 0", o_rd_rows); end
    step();
    rst_n = 1'b1;
    step();
    send_frame(8'h80, 3, st);
    wait_ready(ok);
    checks++; if (o_rd_rows !== 3'd2) begin errors++; $display("FAIL t6_rows: got %0d expected 2", o_rd_rows); end
    for (int r = 0; r < 2; r++) begin
      read_row(v0, v1, d);
      checks++;
      if ({v1, d} !== {1'b1, exp_row(8'h80, 24, r)}) begin
        errors++; $display("FAIL t6_row%0d: got v=%b %h expected v=1 %h", r, v1, d, exp_row(8'h80, 24, r));
      end
    end
  endtask

  initial begin
    s_axis.tdata = '0;
    s_axis.tvalid = 1'b0;
    s_axis.tlast = 1'b0;
    test_reset();
    test_full_rows();
    test_pad_row();
    test_back_to_back();
    test_overflow();
    test_seal_release();
    test_reset_mid_frame();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/act_pingpong_buffer.md
# act_pingpong_buffer

Parametrised ping-pong activation buffer between the AXI-Stream DMA input and the systolic array row feeder. It is the next generation of the fixed 64→96-bit input buffer. It adds:
- a generic S_W→ROW_W byte gearbox;
- real AXIS back-pressure;
- frame sealing on `tlast`, with zero-padded flush of partial rows;
- per-bank row counts and bank full/free handshakes, replacing the external swap pulse;
- sticky overflow detection.

## Interface
- `S_W`, 64: AXIS data width in bits; multiple of 8.
- `ROW_W`, `ARRAY_ROW*8` (96): array row vector width in bits; multiple of 8.
- `DEPTH_LOG2`, 8: log2 of rows per bank.
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_axis_tdata`  in  S_W  stream payload; byte 0 = bits [7:0], first in row order.
- `s_axis_tvalid`  in  1  beat valid.
- `s_axis_tready`  out  1  beat accepted when tvalid && tready.
- `s_axis_tlast`  in  1  last beat of frame; seals the bank.
- `i_rd_en`  in  1  read request for the next row of the current read bank.
- `o_array_vec`  out  ROW_W  row read data.
- `o_vec_valid`  out  1  `o_array_vec` holds a newly read row.
- `o_rd_bank_ready`  out  1  current read bank is sealed and readable.
- `o_rd_rows`  out  DEPTH_LOG2+1  row count of the current read bank.
- `i_rd_release`  in  1  pulse: reader is finished with the current read bank.
- `o_overflow`  out  1  sticky: rows were dropped because a bank was full.
- `i_clr_err`  in  1  clears `o_overflow`.

## Operation
- Storage: RAM of 2·2^DEPTH_LOG2 rows × ROW_W, addressed {bank, row}.
- Byte constants: SB = S_W/8, RB = ROW_W/8, AB = RB+SB (accumulator capacity in bytes).
- Each bank has a `full` flag and a count `cnt` (DEPTH_LOG2+1 bits).
- `wr_bank` and `rd_bank` are independent pointers, both 0 at reset.

Gearbox:
- The accumulator holds `fill` bytes, packed low-first.
- An accepted beat appends SB bytes at offset `fill`.
- Row emit: when `fill ≥ RB` (before the append), the low RB bytes are emitted as a row and the remainder shifts down.
- At most one row is emitted per cycle. Emit and accept may happen in the same cycle.
- `s_axis_tready` = !full[wr_bank] && !flushing && (fill − (emit?RB:0) + SB ≤ AB).
- With S_W ≤ ROW_W, streaming is sustained at one beat per cycle.

Flush and seal, once the `tlast` beat is accepted:
- FLUSH: `flushing`=1 and tready=0.
- Remaining full rows are emitted.
- If 0 < fill < RB, one final row is emitted, zero-padded in its upper bytes.
- SEAL: after the final row is written, `full[wr_bank]`←1, `cnt[wr_bank]`←rows written, `wr_bank` toggles, `fill`←0, and the write row pointer clears.

Write path:
- An emitted row is written at {wr_bank, wr_row}, then wr_row increments.
- If wr_row = 2^DEPTH_LOG2, the row is dropped and `o_overflow`←1.
- The frame still seals, with `cnt` = 2^DEPTH_LOG2.

Read path:
- `o_rd_bank_ready` = full[rd_bank]; `o_rd_rows` = cnt[rd_bank].
- `i_rd_en` is honoured only when ready && rd_ptr < cnt. The row at {rd_bank, rd_ptr} is read and rd_ptr increments. Otherwise the request is ignored.
- `i_rd_release` when ready: `full[rd_bank]`←0, `rd_bank` toggles, rd_ptr←0. When not ready it is ignored.

Simultaneous events:
- Seal and release target different banks and take effect together.
- `i_clr_err` together with a new drop: set wins.

Reset mid-frame: all state clears. Any partial frame and sealed banks are discarded; RAM contents are don't-care.

## Timing
- Reset values:
  - `s_axis_tready`=1 (bank 0 free).
  - `o_vec_valid`=0, `o_array_vec`=0.
  - `o_rd_bank_ready`=0, `o_rd_rows`=0, `o_overflow`=0.
- Read latency: 1 cycle. `i_rd_en` honoured at edge N → `o_vec_valid`=1 and data valid after edge N+1.
- `o_array_vec` holds its value when no read is honoured.
- RAM write is registered, one cycle after the emit decision.
- After the `tlast` handshake edge T:
  - Seal occurs at edge T+1+k, where k = number of rows still to emit (remaining full rows plus any padded row).
  - `o_rd_bank_ready` is high after the seal edge, for that bank when rd_bank = sealed bank.
- Release edge R: the freed bank may raise `s_axis_tready` after edge R when it is `wr_bank`.
- Ready-to-read and read-after-write are coherent: a row sealed at edge E is readable at E+1.

## Structure
- Shared package / params.vh: ROW_BYTES, ACC_BYTES, the derived `clog2` widths, and `ARRAY_ROW`, which supplies the ROW_W default.
- Sub-module `axis_row_gearbox`: accumulator, `fill` counter, emit, flush/pad, and tready contribution. Outputs a row, a row-valid strobe and a last-row strobe.
- The top holds the bank flags and counts, pointers, RAM inference and the read register.

## Test plan
- Reset, then 6 beats (bytes 0..47, tlast on beat 6) → tready stays 1 until flush, 4 rows written; `o_rd_rows`=4; reads return bytes 0–11, 12–23, 24–35, 36–47 with 1-cycle latency.
- 4-beat frame (bytes 0..31) → 3 rows; row 2 = bytes 24..31 in the low 64 bits, upper 32 bits = 0.
- Send two 3-beat frames with no release → both banks full; a third frame sees tready=0. Pulse `i_rd_release` → tready returns next cycle; bank 1 now ready with `o_rd_rows`=2.
- DEPTH_LOG2=2, 9-beat frame → `cnt`=4, `o_overflow`=1 sticky. `i_clr_err` → 0. `i_rd_en` beyond row 3 is ignored (no `o_vec_valid`).
- Seal of bank 1 in the same cycle as release of bank 0 → both effects apply; `rd_bank`=1, ready=1.
- Assert `rst_n` low mid-frame (after 2 beats) → all outputs at reset values. A fresh 3-beat frame then yields `o_rd_rows`=2 with the correct data.
